// File: rtl/load_unit_mem_fsm.sv
// Multi-cycle RISC-V load unit: computes rs1+imm, fetches the aligned word over a
// req/gnt/rvalid handshake, then extracts and extends the byte/half/word with fault flags.
module load_unit_mem_fsm #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [6:0]  LOAD_OPCODE    = 7'b0000011
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic [31:0]           bus_rs1,
   input  logic [31:0]           immediate,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata,
   output logic                  result_valid,
   output logic [31:0]           result_data,
   output logic                  misaligned,
   output logic                  access_fault
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            lane_q, lane_d;
   logic [2:0]            f3_q, f3_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [ADDR_WIDTH-1:0] ea, mem_addr_d;
   logic [31:0]           result_d, load_val;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic                  mis_d, fault_d;

   assign ea = ADDR_WIDTH'(bus_rs1 + immediate);

   // Lane selection uses the offset latched at accept time.
   always_comb begin
      rd_byte = mem_rdata[7:0];
      case (lane_q)
         2'd1:    rd_byte = mem_rdata[15:8];
         2'd2:    rd_byte = mem_rdata[23:16];
         2'd3:    rd_byte = mem_rdata[31:24];
         default: rd_byte = mem_rdata[7:0];
      endcase
      rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
         3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
         3'd2:    load_val = mem_rdata;
         3'd4:    load_val = {24'd0, rd_byte};
         3'd5:    load_val = {16'd0, rd_half};
         default: load_val = 32'd0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      f3_d       = f3_q;
      cnt_inc    = cnt_q + CNT_W'(1);
      cnt_d      = cnt_q;
      mem_addr_d = mem_addr;
      result_d   = result_data;
      mis_d      = 1'b0;
      fault_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && opcode == LOAD_OPCODE) begin
               lane_d = ea[1:0];
               f3_d   = funct3;
               if (funct3 inside {3'd3, 3'd6, 3'd7}) begin
                  state_d  = DONE;
                  fault_d  = 1'b1;
                  result_d = 32'd0;
               end else if (((funct3 == 3'd1 || funct3 == 3'd5) && ea[0]) ||
                            (funct3 == 3'd2 && ea[1:0] != 2'b00)) begin
                  state_d  = DONE;
                  mis_d    = 1'b1;
                  result_d = 32'd0;
               end else begin
                  state_d    = REQ;
                  mem_addr_d = {ea[ADDR_WIDTH-1:2], 2'b00};
               end
            end
         end
         REQ: begin
            if (mem_gnt) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            cnt_d = cnt_inc;
            // Data arriving on the last allowed cycle still wins over the timeout.
            if (mem_rvalid) begin
               state_d  = DONE;
               result_d = load_val;
            end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d  = DONE;
               fault_d  = 1'b1;
               result_d = 32'd0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         lane_q       <= 2'd0;
         f3_q         <= 3'd0;
         cnt_q        <= '0;
         req_ready    <= 1'b1;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         result_valid <= 1'b0;
         result_data  <= 32'd0;
         misaligned   <= 1'b0;
         access_fault <= 1'b0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         f3_q         <= f3_d;
         cnt_q        <= cnt_d;
         req_ready    <= (state_d == IDLE);
         mem_req      <= (state_d == REQ);
         mem_addr     <= mem_addr_d;
         result_valid <= (state_d == DONE);
         result_data  <= result_d;
         misaligned   <= mis_d;
         access_fault <= fault_d;
      end
   end

endmodule

// File: tb/tb_load_unit_mem_fsm.sv
// Directed bench for load_unit_mem_fsm; inputs driven and outputs sampled 1ns after rising edges.
module tb_load_unit_mem_fsm;

   logic        clk, rst_n;
   logic        req_valid, req_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] bus_rs1, immediate;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        result_valid;
   logic [31:0] result_data;
   logic        misaligned, access_fault;

   int checks = 0;
   int errors = 0;

   load_unit_mem_fsm #(
      .ADDR_WIDTH     (32),
      .TIMEOUT_CYCLES (4),
      .LOAD_OPCODE    (7'b0000011)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .opcode       (opcode),
      .funct3       (funct3),
      .bus_rs1      (bus_rs1),
      .immediate    (immediate),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .result_valid (result_valid),
      .result_data  (result_data),
      .misaligned   (misaligned),
      .access_fault (access_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One-cycle load request; returns 1ns after the accept edge.
   task automatic load(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm);
      req_valid = 1'b1;
      opcode    = 7'h03;
      funct3    = f3;
      bus_rs1   = rs1;
      immediate = imm;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; opcode = 7'h03; funct3 = 3'd0;
      bus_rs1 = 32'd0; immediate = 32'd0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      step(); step();
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_valid", 32'(result_valid), 32'd0);
      chk("rst_data", result_data, 32'd0);
      chk("rst_mis", 32'(misaligned), 32'd0);
      chk("rst_fault", 32'(access_fault), 32'd0);
      rst_n = 1'b1;
      step();

      // LW with immediate gnt/rvalid: 3-cycle latency
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      load(3'd2, 32'h100, 32'h4);
      chk("lw_mem_req", 32'(mem_req), 32'd1);
      chk("lw_mem_addr", mem_addr, 32'h104);
      chk("lw_ready_busy", 32'(req_ready), 32'd0);
      chk("lw_valid_req", 32'(result_valid), 32'd0);
      step();
      chk("lw_mem_req_wait", 32'(mem_req), 32'd0);
      chk("lw_valid_wait", 32'(result_valid), 32'd0);
      step();
      chk("lw_valid", 32'(result_valid), 32'd1);
      chk("lw_data", result_data, 32'hDEADBEEF);
      chk("lw_mis", 32'(misaligned), 32'd0);
      chk("lw_fault", 32'(access_fault), 32'd0);
      step();
      chk("lw_valid_drop", 32'(result_valid), 32'd0);
      chk("lw_ready_back", 32'(req_ready), 32'd1);
      chk("lw_data_hold", result_data, 32'hDEADBEEF);

      // LB / LBU at lane 3
      mem_rdata = 32'h80112233;
      load(3'd0, 32'h200, 32'h3);
      chk("lb_mem_addr", mem_addr, 32'h200);
      step(); step();
      chk("lb_valid", 32'(result_valid), 32'd1);
      chk("lb_data", result_data, 32'hFFFFFF80);
      step();
      load(3'd4, 32'h200, 32'h3);
      step(); step();
      chk("lbu_data", result_data, 32'h00000080);
      step();

      // LH upper half, then misaligned LH
      mem_rdata = 32'h9ABC1234;
      load(3'd1, 32'h200, 32'h2);
      step(); step();
      chk("lh_data", result_data, 32'hFFFF9ABC);
      step();
      load(3'd1, 32'h200, 32'h1);
      chk("lhmis_valid", 32'(result_valid), 32'd1);
      chk("lhmis_flag", 32'(misaligned), 32'd1);
      chk("lhmis_fault", 32'(access_fault), 32'd0);
      chk("lhmis_data", result_data, 32'd0);
      chk("lhmis_mem_req", 32'(mem_req), 32'd0);
      step();
      chk("lhmis_flag_clr", 32'(misaligned), 32'd0);
      chk("lhmis_valid_clr", 32'(result_valid), 32'd0);

      // Backpressure: gnt low 5 cycles, competing req_valid ignored
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      load(3'd2, 32'h300, 32'h10);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; bus_rs1 = 32'h700;
         chk("bp_mem_req", 32'(mem_req), 32'd1);
         chk("bp_mem_addr", mem_addr, 32'h310);
         chk("bp_ready", 32'(req_ready), 32'd0);
         step();
      end
      chk("bp_mem_req_end", 32'(mem_req), 32'd1);
      req_valid = 1'b0; mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
      step();
      chk("bp_valid", 32'(result_valid), 32'd1);
      chk("bp_data", result_data, 32'h11223344);
      mem_rvalid = 1'b0;
      step();
      chk("bp_valid_clr", 32'(result_valid), 32'd0);
      step();
      chk("bp_no_queue_req", 32'(mem_req), 32'd0);
      chk("bp_no_queue_valid", 32'(result_valid), 32'd0);

      // Timeout (TIMEOUT_CYCLES=4) then a late rvalid
      mem_gnt = 1'b1;
      load(3'd2, 32'h400, 32'h0);
      chk("to_mem_req", 32'(mem_req), 32'd1);
      step();
      mem_gnt = 1'b0;
      chk("to_mem_req_wait", 32'(mem_req), 32'd0);
      repeat (3) begin
         step();
         chk("to_valid_early", 32'(result_valid), 32'd0);
      end
      step();
      chk("to_valid", 32'(result_valid), 32'd1);
      chk("to_fault", 32'(access_fault), 32'd1);
      chk("to_mis", 32'(misaligned), 32'd0);
      chk("to_data", result_data, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h55;
      step();
      chk("to_late_valid", 32'(result_valid), 32'd0);
      chk("to_fault_clr", 32'(access_fault), 32'd0);
      step();
      chk("to_late_valid2", 32'(result_valid), 32'd0);
      chk("to_ready", 32'(req_ready), 32'd1);
      mem_rvalid = 1'b0;

      // Illegal funct3
      load(3'd3, 32'h500, 32'h0);
      chk("f3_valid", 32'(result_valid), 32'd1);
      chk("f3_fault", 32'(access_fault), 32'd1);
      chk("f3_mis", 32'(misaligned), 32'd0);
      chk("f3_mem_req", 32'(mem_req), 32'd0);
      step();

      // Store opcode ignored
      req_valid = 1'b1; opcode = 7'h23; funct3 = 3'd2; bus_rs1 = 32'h800;
      step();
      chk("st_ready", 32'(req_ready), 32'd1);
      chk("st_mem_req", 32'(mem_req), 32'd0);
      step();
      chk("st_valid", 32'(result_valid), 32'd0);
      chk("st_mem_req2", 32'(mem_req), 32'd0);
      req_valid = 1'b0; opcode = 7'h03;

      // Address wrap
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      load(3'd2, 32'hFFFFFFFC, 32'h8);
      chk("wrap_mem_addr", mem_addr, 32'h4);
      step(); step();
      chk("wrap_valid", 32'(result_valid), 32'd1);
      chk("wrap_data", result_data, 32'hCAFEF00D);
      step();

      // Reset during WAIT
      mem_rvalid = 1'b0;
      load(3'd2, 32'h600, 32'h0);
      step();
      mem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstw_mem_req", 32'(mem_req), 32'd0);
      chk("rstw_ready", 32'(req_ready), 32'd1);
      chk("rstw_valid", 32'(result_valid), 32'd0);
      step();
      rst_n = 1'b1; mem_rvalid = 1'b1;
      repeat (3) begin
         step();
         chk("rstw_no_result", 32'(result_valid), 32'd0);
      end
      mem_rvalid = 1'b0;

      // Reset during REQ drops mem_req asynchronously
      load(3'd2, 32'h640, 32'h0);
      chk("rstr_mem_req_before", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstr_mem_req", 32'(mem_req), 32'd0);
      chk("rstr_mem_addr", mem_addr, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("rstr_valid", 32'(result_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
